// File: rtl/mux_gate_serial_unit_if.sv
// Request/result bus for mux_gate_serial_unit: operand handshake in, result handshake out.
interface mux_gate_serial_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, busy
  );
endinterface

// File: rtl/mux_gate_serial_unit.sv
// Serial bitwise logic unit: one of eight two-input functions evaluated LANES bits per clock
// through a bank of 2:1-mux cells, with valid/ready handshakes on both sides.
module mux_gate_serial_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_gate_serial_unit_if.slave bus
);

  localparam int unsigned BEATS = (LANES > 0) ? WIDTH / LANES : 1;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;

  // Mux data-input sources: constant 0, constant 1, b, ~b
  localparam logic [1:0] SEL_0  = 2'd0;
  localparam logic [1:0] SEL_1  = 2'd1;
  localparam logic [1:0] SEL_B  = 2'd2;
  localparam logic [1:0] SEL_NB = 2'd3;

  if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_param
    $error("mux_gate_serial_unit: WIDTH must be >=1 and a multiple of LANES");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;

  logic             w_accept;
  logic             w_beat;
  logic             w_last;
  logic             w_release;
  logic [1:0]       w_d0_sel;
  logic [1:0]       w_d1_sel;
  logic [31:0]      w_base;
  logic [LANES-1:0] w_a_beat;
  logic [LANES-1:0] w_b_beat;
  logic [LANES-1:0] w_lane;
  logic [WIDTH-1:0] w_part_nxt;

  // State register; in_ready/busy are decoded from the next state so they stay flops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt == S_RUN);
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    w_last      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_beat = 1'b1;
        if (r_cnt == CW'(BEATS - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-op choice of the two mux data inputs shared by every lane
  always_comb begin
    w_d0_sel = SEL_0;
    w_d1_sel = SEL_1;
    case (r_op)
      OP_AND:  begin w_d0_sel = SEL_0;  w_d1_sel = SEL_B;  end
      OP_OR:   begin w_d0_sel = SEL_B;  w_d1_sel = SEL_1;  end
      OP_NAND: begin w_d0_sel = SEL_1;  w_d1_sel = SEL_NB; end
      OP_NOR:  begin w_d0_sel = SEL_NB; w_d1_sel = SEL_0;  end
      OP_XOR:  begin w_d0_sel = SEL_B;  w_d1_sel = SEL_NB; end
      OP_XNOR: begin w_d0_sel = SEL_NB; w_d1_sel = SEL_B;  end
      OP_NOT:  begin w_d0_sel = SEL_1;  w_d1_sel = SEL_0;  end
      default: begin w_d0_sel = SEL_0;  w_d1_sel = SEL_1;  end
    endcase
  end

  assign w_base   = 32'(r_cnt) * LANES;
  assign w_a_beat = LANES'(r_a >> w_base);
  assign w_b_beat = LANES'(r_b >> w_base);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic w_d0;
    logic w_d1;

    always_comb begin
      w_d0 = 1'b0;
      case (w_d0_sel)
        SEL_0:   w_d0 = 1'b0;
        SEL_1:   w_d0 = 1'b1;
        SEL_B:   w_d0 = w_b_beat[l];
        default: w_d0 = ~w_b_beat[l];
      endcase
    end

    always_comb begin
      w_d1 = 1'b0;
      case (w_d1_sel)
        SEL_0:   w_d1 = 1'b0;
        SEL_1:   w_d1 = 1'b1;
        SEL_B:   w_d1 = w_b_beat[l];
        default: w_d1 = ~w_b_beat[l];
      endcase
    end

    assign w_lane[l] = w_a_beat[l] ? w_d1 : w_d0;
  end

  // Partial result is cleared on accept, so OR-ing each new slice into place is enough
  assign w_part_nxt = r_part | (WIDTH'(w_lane) << w_base);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_part      <= '0;
      r_y         <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a    <= bus.a;
        r_b    <= bus.b;
        r_op   <= bus.op;
        r_cnt  <= '0;
        r_part <= '0;
      end
      if (w_beat) begin
        r_part <= w_part_nxt;
        r_cnt  <= r_cnt + CW'(1);
      end
      if (w_last) begin
        r_y         <= w_part_nxt;
        r_zero      <= (w_part_nxt == '0);
        r_out_valid <= 1'b1;
      end
      if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_mux_gate_serial_unit.sv
// Directed bench for mux_gate_serial_unit across three width/lane configurations.
module tb_mux_gate_serial_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_gate_serial_unit_if #(.WIDTH(8)) if8 ();
  mux_gate_serial_unit_if #(.WIDTH(4)) if4 ();
  mux_gate_serial_unit_if #(.WIDTH(8)) if2 ();

  mux_gate_serial_unit #(.WIDTH(8), .LANES(1)) u8 (.clk(clk), .rst(rst), .bus(if8));
  mux_gate_serial_unit #(.WIDTH(4), .LANES(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  mux_gate_serial_unit #(.WIDTH(8), .LANES(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       zero;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  // Offer one request on the 8x1 unit; returns at the negedge after the accepting edge
  task automatic start8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    chk("start8 in_ready", 32'(if8.in_ready), 32'd1);
    if8.in_valid = 1'b1;
    if8.op       = op;
    if8.a        = a;
    if8.b        = b;
    @(posedge clk);
    @(negedge clk);
    if8.in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid on the 8x1 unit, counting clocks and busy cycles
  task automatic wait8(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = int'(if8.busy);
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (if8.out_valid) break;
      if (if8.busy) busy_cnt++;
    end
  endtask

  task automatic release8();
    if8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int bc;
    int seen;
    logic [7:0] prev_y;
    logic [3:0] exp4;

    tbl[0]  = '{3'd3, 8'hA5, 8'h0F, 8'h50, 1'b0};
    tbl[1]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
    tbl[2]  = '{3'd1, 8'h12, 8'h40, 8'h52, 1'b0};
    tbl[3]  = '{3'd2, 8'hFF, 8'hFF, 8'h00, 1'b1};
    tbl[4]  = '{3'd4, 8'hAA, 8'h55, 8'hFF, 1'b0};
    tbl[5]  = '{3'd5, 8'hAA, 8'hAA, 8'hFF, 1'b0};
    tbl[6]  = '{3'd6, 8'h0F, 8'hFF, 8'hF0, 1'b0};
    tbl[7]  = '{3'd7, 8'h81, 8'h00, 8'h81, 1'b0};
    tbl[8]  = '{3'd4, 8'h3C, 8'h3C, 8'h00, 1'b1};
    tbl[9]  = '{3'd2, 8'h0F, 8'h33, 8'hFC, 1'b0};
    tbl[10] = '{3'd3, 8'h00, 8'h00, 8'hFF, 1'b0};
    tbl[11] = '{3'd5, 8'hC3, 8'h5A, 8'h66, 1'b0};

    if8.in_valid = 1'b0; if8.op = '0; if8.a = '0; if8.b = '0; if8.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.op = '0; if4.a = '0; if4.b = '0; if4.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.op = '0; if2.a = '0; if2.b = '0; if2.out_ready = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset y", 32'(if8.y), 32'h0);
    chk("reset zero", 32'(if8.zero), 32'd1);
    chk("reset out_valid", 32'(if8.out_valid), 32'd0);
    chk("reset in_ready", 32'(if8.in_ready), 32'd1);
    chk("reset busy", 32'(if8.busy), 32'd0);
    rst = 1'b0;

    prev_y = 8'h00;
    for (int i = 0; i < 12; i++) begin
      start8(tbl[i].op, tbl[i].a, tbl[i].b);
      chk("y held during run", 32'(if8.y), 32'(prev_y));
      chk("in_ready low in run", 32'(if8.in_ready), 32'd0);
      wait8(lat, bc);
      chk("latency 8x1", 32'(lat), 32'd8);
      if (i == 0) chk("busy cycles 8x1", 32'(bc), 32'd8);
      chk("table y", 32'(if8.y), 32'(tbl[i].y));
      chk("table zero", 32'(if8.zero), 32'(tbl[i].zero));
      release8();
      chk("release in_ready", 32'(if8.in_ready), 32'd1);
      chk("release out_valid", 32'(if8.out_valid), 32'd0);
      prev_y = tbl[i].y;
    end

    // Backpressure with a competing request held on the input
    start8(3'd0, 8'hF0, 8'h3C);
    wait8(lat, bc);
    chk("bp first y", 32'(if8.y), 32'h30);
    if8.in_valid = 1'b1; if8.op = 3'd1; if8.a = 8'h01; if8.b = 8'h02;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp out_valid held", 32'(if8.out_valid), 32'd1);
      chk("bp y held", 32'(if8.y), 32'h30);
      chk("bp in_ready low", 32'(if8.in_ready), 32'd0);
      chk("bp busy low", 32'(if8.busy), 32'd0);
    end
    if8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.out_ready = 1'b0;
    chk("bp idle in_ready", 32'(if8.in_ready), 32'd1);
    chk("bp idle out_valid", 32'(if8.out_valid), 32'd0);
    chk("bp idle y", 32'(if8.y), 32'h30);
    @(posedge clk);
    @(negedge clk);
    if8.in_valid = 1'b0;
    chk("bp second accepted", 32'(if8.busy), 32'd1);
    wait8(lat, bc);
    chk("bp second latency", 32'(lat), 32'd8);
    chk("bp second y", 32'(if8.y), 32'h03);
    release8();

    // Reset in the middle of a run discards the request
    start8(3'd0, 8'hFF, 8'hFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrun rst y", 32'(if8.y), 32'h0);
    chk("midrun rst zero", 32'(if8.zero), 32'd1);
    chk("midrun rst out_valid", 32'(if8.out_valid), 32'd0);
    chk("midrun rst in_ready", 32'(if8.in_ready), 32'd1);
    chk("midrun rst busy", 32'(if8.busy), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.out_valid) seen++;
    end
    chk("midrun no result", 32'(seen), 32'd0);
    start8(3'd1, 8'h00, 8'h00);
    wait8(lat, bc);
    chk("post rst latency", 32'(lat), 32'd8);
    chk("post rst y", 32'(if8.y), 32'h0);
    chk("post rst zero", 32'(if8.zero), 32'd1);
    release8();

    // Operand changes after accept must not reach the in-flight result
    @(negedge clk);
    if2.in_valid = 1'b1; if2.op = 3'd4; if2.a = 8'h3C; if2.b = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    if2.in_valid = 1'b0; if2.op = 3'd0; if2.a = 8'h00; if2.b = 8'h00;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (if2.out_valid) break;
    end
    chk("lanes2 latency", 32'(lat), 32'd4);
    chk("lanes2 y", 32'(if2.y), 32'hC3);
    chk("lanes2 zero", 32'(if2.zero), 32'd0);

    // All ops and operand pairs on the fully parallel unit
    for (int op = 0; op < 8; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          @(negedge clk);
          if4.in_valid = 1'b1;
          if4.op = 3'(op);
          if4.a  = 4'(a);
          if4.b  = 4'(b);
          @(posedge clk);
          @(negedge clk);
          if4.in_valid = 1'b0;
          @(posedge clk);
          @(negedge clk);
          exp4 = ref4(3'(op), 4'(a), 4'(b));
          chk($sformatf("sweep op%0d a%0h b%0h", op, a, b),
              {27'd0, if4.out_valid, if4.zero, if4.y},
              {27'd0, 1'b1, (exp4 == 4'h0), exp4});
          if (op == 5 && a == 12 && b == 10) chk("xnor C A", 32'(if4.y), 32'h9);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
